// File: rtl/mux_scan_sequencer_if.sv
// ============================================================================
// mux_scan_sequencer_if : request/result bundle between a scan client and the
// sequencer. Revision 1.0
// ============================================================================
`default_nettype none

interface mux_scan_sequencer_if #(
  parameter int NCH = 4
);
  logic           start;
  logic           abort;
  logic           busy;
  logic           valid;
  logic [NCH-1:0] word;
`ifdef MUX_SCAN_PARITY_EN
  logic           parity;

  modport master (output start, abort, input busy, valid, word, parity);
  modport slave  (input start, abort, output busy, valid, word, parity);
`else
  modport master (output start, abort, input busy, valid, word);
  modport slave  (input start, abort, output busy, valid, word);
`endif
endinterface

`default_nettype wire

// File: rtl/mux_scan_sequencer.sv
// ============================================================================
// mux_scan_sequencer : steps a mux select through every channel, samples the
// mux output after a settle delay and publishes one word per scan.
// Optional feature macro: MUX_SCAN_PARITY_EN (adds the parity output).
// Revision 1.0
// ============================================================================
`default_nettype none

module mux_scan_sequencer #(
  parameter int SEL_W  = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_scan_sequencer_if.slave  bus,
  input  logic                 mux_out,
  output logic [SEL_W-1:0]     sel
);

  localparam int                NCH      = 2 ** SEL_W;
  localparam logic [3:0]        C_SETTLE = 4'(SETTLE);
  localparam logic [SEL_W-1:0]  C_LAST   = SEL_W'(NCH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q,  state_d;
  logic [SEL_W-1:0] sel_q,    sel_d;
  logic [3:0]       cnt_q,    cnt_d;
  logic [NCH-1:0]   shadow_q, shadow_d;
  logic [NCH-1:0]   word_q,   word_d;
  logic             busy_q,   busy_d;
  logic             valid_q,  valid_d;
`ifdef MUX_SCAN_PARITY_EN
  logic             parity_q, parity_d;
`endif

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    word_d   = word_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        sel_d = '0;
        if (bus.start) begin
          state_d = S_SETTLE;
          cnt_d   = C_SETTLE;
          busy_d  = 1'b1;
        end
      end
      S_SETTLE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          sel_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          // A zero or one count still spends exactly one cycle settling.
          cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
          if (cnt_q <= 4'd1) begin
            state_d = S_SAMPLE;
          end
        end
      end
      S_SAMPLE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          sel_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          shadow_d[sel_q] = mux_out;
          if (sel_q == C_LAST) begin
            state_d = S_DONE;
          end else begin
            sel_d   = sel_q + SEL_W'(1);
            cnt_d   = C_SETTLE;
            state_d = S_SETTLE;
          end
        end
      end
      S_DONE: begin
        word_d  = shadow_q;
        valid_d = 1'b1;
        sel_d   = '0;
`ifdef MUX_SCAN_PARITY_EN
        parity_d = ^shadow_q;
`endif
        // The scan completes regardless of abort; abort only blocks a restart.
        if (bus.start && !bus.abort) begin
          state_d = S_SETTLE;
          cnt_d   = C_SETTLE;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        sel_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      word_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      word_q   <= word_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
`ifdef MUX_SCAN_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign sel       = sel_q;
  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.word  = word_q;
`ifdef MUX_SCAN_PARITY_EN
  assign bus.parity = parity_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
// ============================================================================
// tb_mux_scan_sequencer : directed + randomized checks of the scan sequencer
// against a timing/value model derived from the scan rules. Revision 1.0
// ============================================================================
`default_nettype none

module tb_mux_scan_sequencer;

  localparam int SEL_W = 2;
  localparam int NCH   = 4;
  localparam int SETTLE = 1;

  function automatic int per_chan(input int s);
    return ((s > 1) ? s : 1) + 1;
  endfunction

  function automatic int scan_latency(input int s);
    return NCH * per_chan(s) + 1;
  endfunction

  localparam int P = ((SETTLE > 1) ? SETTLE : 1) + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [NCH-1:0] in_vec;
  logic [SEL_W-1:0] sel, sel0, sel3;
  logic mux_out, mux_out0, mux_out3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_scan_sequencer_if #(.NCH(NCH)) bus ();
  mux_scan_sequencer_if #(.NCH(NCH)) if0 ();
  mux_scan_sequencer_if #(.NCH(NCH)) if3 ();

  // Behavioural 4-to-1 mux models, one per sequencer instance.
  assign mux_out  = in_vec[sel];
  assign mux_out0 = in_vec[sel0];
  assign mux_out3 = in_vec[sel3];

  mux_scan_sequencer #(.SEL_W(SEL_W), .SETTLE(SETTLE)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .mux_out(mux_out), .sel(sel));
  mux_scan_sequencer #(.SEL_W(SEL_W), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave), .mux_out(mux_out0), .sel(sel0));
  mux_scan_sequencer #(.SEL_W(SEL_W), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave), .mux_out(mux_out3), .sel(sel3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Called in the cycle right after the start edge. Select must dwell P cycles
  // per channel, then the result appears one cycle after the final sample.
  task automatic expect_scan(input logic [NCH-1:0] v, input logic [NCH-1:0] next_v,
                             input bit chain, input int repulse_t, input bit prev_valid);
    int exp_sel;
    for (int t = 0; t <= NCH * P; t++) begin
      exp_sel = t / P;
      if (exp_sel > NCH - 1) exp_sel = NCH - 1;
      chk("scan_sel", 32'(sel), 32'(exp_sel));
      chk("scan_busy", 32'(bus.busy), 32'd1);
      chk("scan_valid", 32'(bus.valid), (t == 0) ? 32'(prev_valid) : 32'd0);
      if (repulse_t >= 0 && t == repulse_t) bus.start = 1'b1;
      else if (repulse_t >= 0 && t == repulse_t + 1) bus.start = 1'b0;
      if (t == NCH * P) in_vec = next_v;
      tick();
    end
    chk("done_valid", 32'(bus.valid), 32'd1);
    chk("done_word", 32'(bus.word), 32'(v));
    chk("done_busy", 32'(bus.busy), 32'(chain));
    chk("done_sel", 32'(sel), 32'd0);
`ifdef MUX_SCAN_PARITY_EN
    chk("done_parity", 32'(bus.parity), 32'(^v));
`endif
    if (!chain) begin
      tick();
      chk("post_valid", 32'(bus.valid), 32'd0);
      chk("post_busy", 32'(bus.busy), 32'd0);
      chk("post_word", 32'(bus.word), 32'(v));
    end
  endtask

  task automatic abort_scan(input int ch, input int off, input bit with_start,
                            input logic [NCH-1:0] prev_word);
    start_pulse();
    for (int t = 0; t < ch * P + off; t++) tick();
    bus.abort = 1'b1;
    bus.start = with_start;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_sel", 32'(sel), 32'd0);
    for (int t = 0; t < NCH * P + 2; t++) begin
      chk("abort_valid", 32'(bus.valid), 32'd0);
      chk("abort_word", 32'(bus.word), 32'(prev_word));
      tick();
    end
    chk("abort_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [NCH-1:0] v;
    int lat1, lat0, lat3;
    logic [NCH-1:0] w0, w3;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0;
    if0.start = 1'b0; if0.abort = 1'b0;
    if3.start = 1'b0; if3.abort = 1'b0;
    in_vec = 4'b1010;
    #3;
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_word", 32'(bus.word), 32'd0);
`ifdef MUX_SCAN_PARITY_EN
    chk("rst_parity", 32'(bus.parity), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();
    chk("idle_sel", 32'(sel), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Basic scan of 1010.
    start_pulse();
    expect_scan(4'b1010, 4'b1010, 1'b0, -1, 1'b0);

    // Abort while on channel 2, then abort with concurrent start.
    abort_scan(2, 0, 1'b0, 4'b1010);
    abort_scan($urandom_range(0, NCH - 1), $urandom_range(0, P - 1), 1'b1, 4'b1010);

    // Abort in IDLE has no effect.
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("idle_abort_busy", 32'(bus.busy), 32'd0);
    chk("idle_abort_word", 32'(bus.word), 32'b1010);

    // Back-to-back scans with start held through DONE.
    in_vec = 4'b0010;
    bus.start = 1'b1;
    tick();
    expect_scan(4'b0010, 4'b1110, 1'b1, -1, 1'b0);
    bus.start = 1'b0;
    expect_scan(4'b1110, 4'b1110, 1'b0, -1, 1'b1);

    // Start re-pulsed mid-scan is ignored.
    in_vec = 4'b1011;
    start_pulse();
    expect_scan(4'b1011, 4'b1011, 1'b0, 3, 1'b0);

    // Asynchronous reset while sel=3, away from any clock edge.
    in_vec = 4'b0110;
    start_pulse();
    for (int t = 0; t < 3 * P; t++) tick();
    chk("pre_rst_sel", 32'(sel), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel", 32'(sel), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_valid", 32'(bus.valid), 32'd0);
    chk("arst_word", 32'(bus.word), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    start_pulse();
    expect_scan(4'b0110, 4'b0110, 1'b0, -1, 1'b0);

    // Randomized scans with random ignored start pulses.
    for (int i = 0; i < 6; i++) begin
      v = NCH'($urandom);
      in_vec = v;
      start_pulse();
      expect_scan(v, v, 1'b0, $urandom_range(0, NCH * P - 2), 1'b0);
    end

    // Latency across SETTLE builds.
    in_vec = 4'b1011;
    lat1 = 0; lat0 = 0; lat3 = 0; w0 = '0; w3 = '0;
    bus.start = 1'b1; if0.start = 1'b1; if3.start = 1'b1;
    tick();
    bus.start = 1'b0; if0.start = 1'b0; if3.start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (bus.valid && lat1 == 0) lat1 = c;
      if (if0.valid && lat0 == 0) begin lat0 = c; w0 = if0.word; end
      if (if3.valid && lat3 == 0) begin lat3 = c; w3 = if3.word; end
    end
    chk("lat_settle1", 32'(lat1), 32'(scan_latency(1)));
    chk("lat_settle0", 32'(lat0), 32'(scan_latency(0)));
    chk("lat_settle3", 32'(lat3), 32'(scan_latency(3)));
    chk("word_settle0", 32'(w0), 32'b1011);
    chk("word_settle3", 32'(w3), 32'b1011);
    chk("word_settle1", 32'(bus.word), 32'b1011);
`ifdef MUX_SCAN_PARITY_EN
    chk("parity_1011", 32'(bus.parity), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream/downstream companion to the 4-to-1 behavioural mux: drives the mux select lines and captures the mux's single-bit output.
- On each start request it steps select through every channel, waits a settle interval per channel, samples the mux output, and assembles one parallel word.
- Completion is reported with a one-cycle valid pulse.
- Lets the team read back all mux inputs through the mux itself, for self-check and scan-out.

Parameters:
- SEL_W, 2, select width; channel count NCH = 2**SEL_W (4 by default, matching the 4-to-1 mux).
- SETTLE, 1, wait cycles after each select change before sampling; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  scan request, sampled on rising edge.
- abort  input  1  cancels an in-progress scan.
- mux_out  input  1  output bit of the driven mux.
- sel  output  SEL_W  select lines to the mux.
- busy  output  1  high while a scan is in progress.
- word  output  NCH  last completed scan; bit i = mux_out sampled with sel=i.
- valid  output  1  one-cycle pulse when word updates.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values (async, immediate on rst_n low): sel=0, busy=0, word=0, valid=0, internal shadow=0, settle counter=0, state IDLE.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 -> SETTLE; sel=0, counter=SETTLE, busy=1.
  - Otherwise hold; sel holds 0.
- SETTLE:
  - Counter decrements each cycle.
  - Counter==0 -> SAMPLE. With SETTLE=0, this state lasts 1 cycle.
- SAMPLE (1 cycle): shadow[sel] <= mux_out.
  - sel==NCH-1 -> DONE.
  - Otherwise sel+1, counter reloads, -> SETTLE.
- DONE (1 cycle): word <= shadow, valid=1, busy=0, sel returns to 0.
  - start=1 in this cycle -> SETTLE (back-to-back scan).
  - Otherwise -> IDLE.
- Timing per channel: max(SETTLE,1)+1 cycles. Define P = max(SETTLE,1)+1.
- Latency: start sampled at edge k -> valid high after edge k + NCH*P + 1.
  - Default SETTLE=1, NCH=4: valid after edge k+9.
- Select sequence at default: 0,0,1,1,2,2,3,3, then 0.
- start while busy (SETTLE/SAMPLE): ignored; no queuing.
- abort while busy: next edge -> IDLE, sel=0, busy=0, no valid pulse; word keeps its previous value.
- abort has priority over start when both are high in the same cycle. abort in IDLE: no effect.
- word changes only in DONE and holds otherwise; valid is never high two consecutive cycles unless scans are back-to-back (one pulse per completed scan).
- sel is registered and glitch-free; it never exceeds NCH-1.
- rst_n low mid-scan: all state clears immediately; no partial word is ever published.

Optional Feature:
- MUX_SCAN_PARITY_EN:
  - Defined: adds output port parity (1 bit, reset 0), updated in DONE alongside word as XOR of the shadow bits (even parity of word).
  - Undefined: parity port and logic absent; all other behaviour is identical.

Test Plan:
- Mux model fed in=4'b1010; reset release; pulse start -> sel steps 0,0,1,1,2,2,3,3; valid pulses 9 cycles after the start edge; word=4'b1010, busy falls with valid.
- in=4'b0010, then in=4'b1110 back-to-back, start held through DONE -> two valid pulses 9 cycles apart; word=4'b0010 then 4'b1110.
- abort asserted when sel=2 -> busy=0 next cycle, sel=0, no valid; word unchanged from prior scan (4'b1010).
- start re-pulsed mid-scan with in=4'b1011 -> ignored; single valid pulse; word=4'b1011.
- rst_n low when sel=3 -> sel, word, busy, valid all 0 immediately, without waiting for a clock edge; a new start completes normally.
- SETTLE=0 and SETTLE=3 builds, in=4'b1011 -> valid after edge k+9 and k+17 respectively. With MUX_SCAN_PARITY_EN defined, parity=1.
